// File: rtl/ntt_pkg.sv
// Shared types, defaults and elaboration-time helpers for the NTT datapath.
package ntt_pkg;

  localparam int DEFAULT_COEFF_W = 12;
  localparam int DEFAULT_Q       = 3329;
  localparam int DEFAULT_N       = 256;

  typedef logic [DEFAULT_COEFF_W-1:0] coeff_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADED,
    S_RUN,
    S_SCALE,
    S_UNLOAD
  } state_t;

  // Reverse the low 'bits' bits of k.
  function automatic logic [63:0] bitrev(input logic [63:0] k, input int unsigned bits);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < bits; i++) begin
      r = (r << 1) | ((k >> i) & 64'd1);
    end
    return r;
  endfunction

  // base^exp mod q by square-and-multiply; operands stay below 2^32.
  function automatic logic [63:0] modpow(input logic [63:0] base, input logic [63:0] exp,
                                         input logic [63:0] q);
    logic [63:0] r, b, e;
    r = 64'd1 % q;
    b = base % q;
    e = exp;
    for (int unsigned i = 0; i < 32; i++) begin
      if (e[0]) r = (r * b) % q;
      b = (b * b) % q;
      e = e >> 1;
    end
    return r;
  endfunction

  // Barrett reduction of x < 2^k into [0, q-1], with mu = floor(2^k / q).
  function automatic logic [63:0] barrett_reduce(input logic [63:0] x, input logic [63:0] q,
                                                 input logic [63:0] mu, input int unsigned k);
    logic [63:0] qe, r;
    qe = (x * mu) >> k;
    r  = x - qe * q;
    if (r >= q) r = r - q;
    if (r >= q) r = r - q;
    return r;
  endfunction

  // Twiddle table entry: root^bitrev_bits(k) mod q.
  function automatic logic [63:0] zeta_gen(input logic [63:0] k, input logic [63:0] root,
                                           input logic [63:0] q, input int unsigned bits);
    return modpow(root, bitrev(k, bits), q);
  endfunction

endpackage

// File: rtl/ntt_butterfly.sv
// Combinational NTT butterfly: Cooley-Tukey when mode=0, Gentleman-Sande when mode=1.
module ntt_butterfly
  import ntt_pkg::*;
#(
  parameter int COEFF_W = DEFAULT_COEFF_W,
  parameter int Q       = DEFAULT_Q
) (
  input  logic [COEFF_W-1:0] a,
  input  logic [COEFF_W-1:0] b,
  input  logic [COEFF_W-1:0] zeta,
  input  logic               mode,
  output logic [COEFF_W-1:0] a_res,
  output logic [COEFF_W-1:0] b_res
);

  localparam logic [63:0]      MU = (64'd1 << (2 * COEFF_W)) / 64'(Q);
  localparam logic [COEFF_W:0] QX = (COEFF_W + 1)'(Q);

  logic [COEFF_W:0]     diff_inv, sum, diff_fwd;
  logic [COEFF_W-1:0]   d_inv, mul_op, t;
  logic [2*COEFF_W-1:0] prod;

  // Single modular multiplier shared by both directions; operand selected by mode.
  always_comb begin
    diff_inv = {1'b0, b} + QX - {1'b0, a};
    d_inv    = (diff_inv >= QX) ? COEFF_W'(diff_inv - QX) : COEFF_W'(diff_inv);
    mul_op   = mode ? d_inv : b;
    prod     = {{COEFF_W{1'b0}}, zeta} * {{COEFF_W{1'b0}}, mul_op};
    t        = COEFF_W'(barrett_reduce(64'(prod), 64'(Q), MU, 2 * COEFF_W));
    sum      = {1'b0, a} + {1'b0, (mode ? b : t)};
    a_res    = (sum >= QX) ? COEFF_W'(sum - QX) : COEFF_W'(sum);
    diff_fwd = {1'b0, a} + QX - {1'b0, t};
    b_res    = mode ? t : ((diff_fwd >= QX) ? COEFF_W'(diff_fwd - QX) : COEFF_W'(diff_fwd));
  end

endmodule

// File: rtl/ntt_engine.sv
// Iterative in-place negacyclic NTT/INTT engine: stream in, transform, stream out.
module ntt_engine
  import ntt_pkg::*;
#(
  parameter int N       = DEFAULT_N,
  parameter int Q       = DEFAULT_Q,
  parameter int COEFF_W = DEFAULT_COEFF_W,
  parameter int ROOT    = 17,
  parameter int N_INV   = 3303
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COEFF_W-1:0] in_data,
  input  logic               start,
  input  logic               mode,
  output logic               busy,
  output logic               done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COEFF_W-1:0] out_data
);

  localparam int AW = $clog2(N);
  localparam int L  = AW - 1;
  localparam int CW = AW - 1;
  localparam int LW = $clog2(L + 1);
  localparam logic [63:0] MU = (64'd1 << (2 * COEFF_W)) / 64'(Q);

  state_t state, state_d;
  logic [AW-1:0] idx, idx_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [LW-1:0] layer, layer_d;
  logic          mode_q, mode_d, done_d;

  logic [COEFF_W-1:0] ram [N];
  logic [COEFF_W-1:0] zeta_tab [N/2];

  logic [AW-1:0] sh, grp, off_mask, cnt_w, idx_a, idx_b;
  logic [CW-1:0] kk;

  logic [COEFF_W-1:0]   bf_a, bf_b, scaled;
  logic [2*COEFF_W-1:0] scale_prod;

  logic               we_a, we_b;
  logic [AW-1:0]      wa;
  logic [COEFF_W-1:0] wd_a;

  for (genvar g = 0; g < N/2; g++) begin : g_zeta
    localparam logic [63:0] ZV = zeta_gen(64'(g), 64'(ROOT), 64'(Q), L);
    assign zeta_tab[g] = COEFF_W'(ZV);
  end

  // Butterfly addressing derived from (layer, cnt): sh = log2(len); the pair index
  // is cnt with a zero inserted at bit sh, and the group number picks the twiddle.
  always_comb begin
    cnt_w    = AW'(cnt);
    sh       = mode_q ? (AW'(layer) + AW'(1)) : (AW'(L) - AW'(layer));
    off_mask = (AW'(1) << sh) - AW'(1);
    grp      = cnt_w >> sh;
    idx_a    = (grp << (sh + AW'(1))) | (cnt_w & off_mask);
    idx_b    = idx_a | (AW'(1) << sh);
    kk       = mode_q ? CW'((AW'(1) << (AW'(L) - AW'(layer))) - AW'(1) - grp)
                      : CW'((AW'(1) << layer) + grp);
  end

  ntt_butterfly #(
    .COEFF_W(COEFF_W),
    .Q      (Q)
  ) u_bf (
    .a    (ram[idx_a]),
    .b    (ram[idx_b]),
    .zeta (zeta_tab[kk]),
    .mode (mode_q),
    .a_res(bf_a),
    .b_res(bf_b)
  );

  // Final inverse scaling by (N/2)^-1 for the coefficient at idx.
  always_comb begin
    scale_prod = {{COEFF_W{1'b0}}, ram[idx]} * {{COEFF_W{1'b0}}, COEFF_W'(N_INV)};
    scaled     = COEFF_W'(barrett_reduce(64'(scale_prod), 64'(Q), MU, 2 * COEFF_W));
  end

  // Coefficient storage: load / butterfly / scale writes; contents not reset.
  always_ff @(posedge clk) begin
    if (we_a) ram[wa] <= wd_a;
    if (we_b) ram[idx_b] <= bf_b;
  end

  // Control state, counters and done pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      cnt    <= '0;
      layer  <= '0;
      mode_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      cnt    <= cnt_d;
      layer  <= layer_d;
      mode_q <= mode_d;
      done   <= done_d;
    end
  end

  // Next-state, RAM write control and handshake outputs.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    cnt_d     = cnt;
    layer_d   = layer;
    mode_d    = mode_q;
    done_d    = 1'b0;
    we_a      = 1'b0;
    we_b      = 1'b0;
    wa        = idx_a;
    wd_a      = bf_a;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = done;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          we_a  = 1'b1;
          wa    = idx;
          wd_a  = in_data;
          idx_d = idx + AW'(1);
          if (idx == AW'(N - 1)) state_d = S_LOADED;
        end
      end
      S_LOADED: begin
        if (start) begin
          mode_d  = mode;
          layer_d = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        we_a  = 1'b1;
        we_b  = 1'b1;
        cnt_d = cnt + CW'(1);
        if (&cnt) begin
          layer_d = layer + LW'(1);
          if (layer == LW'(L - 1)) begin
            idx_d = '0;
            if (mode_q) begin
              state_d = S_SCALE;
            end else begin
              state_d = S_UNLOAD;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_SCALE: begin
        busy  = 1'b1;
        we_a  = 1'b1;
        wa    = idx;
        wd_a  = scaled;
        idx_d = idx + AW'(1);
        if (idx == AW'(N - 1)) begin
          state_d = S_UNLOAD;
          done_d  = 1'b1;
        end
      end
      S_UNLOAD: begin
        out_valid = 1'b1;
        out_data  = ram[idx];
        if (out_ready) begin
          idx_d = idx + AW'(1);
          if (idx == AW'(N - 1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ntt_engine.sv
// Self-checking bench for ntt_engine against a loop-level software NTT model.
module tb_ntt_engine;

  localparam int N = 256;
  localparam int Q = 3329;
  localparam int W = 12;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         start;
  logic         mode;
  logic         busy;
  logic         done;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  int unsigned vectors;
  int unsigned miscompares;

  int unsigned src  [N];
  int unsigned orig [N];
  int unsigned mdl  [N];
  int unsigned got  [N];
  int unsigned zt   [N/2];

  ntt_engine #(
    .N      (N),
    .Q      (Q),
    .COEFF_W(W),
    .ROOT   (17),
    .N_INV  (3303)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .start    (start),
    .mode     (mode),
    .busy     (busy),
    .done     (done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, miscompares=%0d", miscompares);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned mulmod(input int unsigned x, input int unsigned y);
    return 32'((64'(x) * 64'(y)) % 64'(Q));
  endfunction

  // Forward negacyclic NTT, textbook Cooley-Tukey loops over mdl[].
  task automatic model_fwd();
    int unsigned k, t, a0, z;
    k = 1;
    for (int unsigned len = N/2; len >= 2; len = len / 2) begin
      for (int unsigned st = 0; st < N; st += 2 * len) begin
        z = zt[k];
        k++;
        for (int unsigned j = st; j < st + len; j++) begin
          t          = mulmod(z, mdl[j + len]);
          a0         = mdl[j];
          mdl[j]     = (a0 + t) % Q;
          mdl[j+len] = (a0 + Q - t) % Q;
        end
      end
    end
  endtask

  task automatic load_src();
    for (int unsigned i = 0; i < N; i++) begin
      while ($urandom_range(7) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = W'(src[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("in_ready_loaded", 64'(in_ready), 64'd0);
    check("busy_loaded", 64'(busy), 64'd0);
  endtask

  task automatic run_xform(input logic m, input int unsigned lat);
    int unsigned cyc, busy_low;
    bit seen;
    cyc = 0; busy_low = 0; seen = 1'b0;
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start    = 1'b0;
    mode     = ~m;
    in_valid = 1'b1;
    in_data  = W'($urandom_range(Q - 1));
    while (cyc <= lat + 64) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy) busy_low++;
      @(posedge clk); #1;
      cyc++;
      start   = (cyc == 100);
      in_data = W'($urandom_range(Q - 1));
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    check(m ? "inv_latency" : "fwd_latency", 64'(cyc), 64'(lat));
    check("busy_during_run", 64'(busy_low), 64'd0);
    check("busy_at_done", 64'(busy), 64'd1);
  endtask

  task automatic unload(input bit bp);
    int unsigned n, cyc, dcnt;
    logic [W-1:0] held;
    bit stalled;
    n = 0; cyc = 0; dcnt = 0; stalled = 1'b0; held = '0;
    while (n < N && cyc < 4 * N) begin
      out_ready = bp ? (cyc % 3 == 0) : 1'b1;
      if (done) dcnt++;
      if (!out_valid) begin
        check("out_valid_unload", 64'(out_valid), 64'd1);
        break;
      end
      if (bp) begin
        check("in_ready_unload", 64'(in_ready), 64'd0);
        if (stalled) check("stall_hold", 64'(out_data), 64'(held));
      end
      if (out_ready) begin
        got[n]  = 32'(out_data);
        n++;
        stalled = 1'b0;
      end else begin
        held    = out_data;
        stalled = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    check("unload_count", 64'(n), 64'(N));
    check("done_width", 64'(dcnt), 64'd1);
    check("in_ready_after", 64'(in_ready), 64'd1);
    check("out_valid_after", 64'(out_valid), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
  endtask

  task automatic fwd_vs_model(input string tag, input bit bp);
    for (int unsigned i = 0; i < N; i++) mdl[i] = src[i];
    model_fwd();
    load_src();
    run_xform(1'b0, 896);
    unload(bp);
    for (int unsigned i = 0; i < N; i++) check(tag, 64'(got[i]), 64'(mdl[i]));
  endtask

  initial begin
    int unsigned br, p, dcount, bcount;
    vectors = 0; miscompares = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; start = 1'b0; mode = 1'b0; out_ready = 1'b0;

    for (int unsigned k = 0; k < N/2; k++) begin
      br = 0;
      for (int unsigned b = 0; b < 7; b++) br = (br << 1) | ((k >> b) & 1);
      p = 1;
      for (int unsigned e = 0; e < br; e++) p = mulmod(p, 17);
      zt[k] = p;
    end

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("post_reset");

    // forward transform of a delta
    for (int unsigned i = 0; i < N; i++) src[i] = (i == 0) ? 1 : 0;
    load_src();
    run_xform(1'b0, 896);
    unload(1'b0);
    for (int unsigned i = 0; i < N; i++) check("fwd_delta", 64'(got[i]), (i % 2 == 0) ? 64'd1 : 64'd0);

    // inverse brings it back to the delta
    for (int unsigned i = 0; i < N; i++) src[i] = got[i];
    load_src();
    run_xform(1'b1, 1152);
    unload(1'b0);
    for (int unsigned i = 0; i < N; i++) check("inv_delta", 64'(got[i]), (i == 0) ? 64'd1 : 64'd0);

    // random round trips
    for (int unsigned r = 0; r < 20; r++) begin
      for (int unsigned i = 0; i < N; i++) begin
        src[i]  = $urandom_range(Q - 1);
        orig[i] = src[i];
      end
      fwd_vs_model("rt_fwd_model", 1'b0);
      for (int unsigned i = 0; i < N; i++) src[i] = got[i];
      load_src();
      run_xform(1'b1, 1152);
      unload(1'b0);
      for (int unsigned i = 0; i < N; i++) check("rt_identity", 64'(got[i]), 64'(orig[i]));
    end

    // all coefficients at Q-1
    for (int unsigned i = 0; i < N; i++) src[i] = Q - 1;
    fwd_vs_model("edge_model", 1'b0);
    for (int unsigned i = 0; i < N; i++) check("edge_range", 64'(got[i] < Q), 64'd1);

    // output backpressure, ready one cycle in three
    for (int unsigned i = 0; i < N; i++) src[i] = $urandom_range(Q - 1);
    fwd_vs_model("bp_model", 1'b1);

    // reset in the middle of a forward run
    for (int unsigned i = 0; i < N; i++) src[i] = $urandom_range(Q - 1);
    load_src();
    start = 1'b1;
    mode  = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (399) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_run_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    dcount = 0; bcount = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (done) dcount++;
      if (busy) bcount++;
    end
    check("no_done_after_reset", 64'(dcount), 64'd0);
    check("no_busy_after_reset", 64'(bcount), 64'd0);
    check("in_ready_after_reset", 64'(in_ready), 64'd1);
    for (int unsigned i = 0; i < N; i++) src[i] = $urandom_range(Q - 1);
    fwd_vs_model("post_reset_model", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
